// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time clock divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 32;
  localparam int BURST_W   = 16;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and toggle engine; clk_out flips whenever cnt reaches half.
module clk_div_core #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_half,
  output logic             o_clk_out,
  output logic             o_toggle_rise,
  output logic             o_toggle_fall
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out;
  logic             w_hit;

  assign w_hit         = i_run && (r_cnt == i_half);
  assign o_toggle_rise = w_hit && !r_clk_out;
  assign o_toggle_fall = w_hit && r_clk_out;
  assign o_clk_out     = r_clk_out;

  // half is never 0, so cnt restarts at 1 before it could pass half
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= CNT_W'(1);
      r_clk_out <= 1'b0;
    end else if (i_clr) begin
      r_cnt     <= CNT_W'(1);
      r_clk_out <= 1'b0;
    end else if (w_hit) begin
      r_cnt     <= CNT_W'(1);
      r_clk_out <= ~r_clk_out;
    end else if (i_run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Start/stop FSM, config handshake and pending ratio for the 50% clock divider.
// Optional burst mode (i_burst_len / o_done) is enabled by CLK_DIV_CTRL_BURST_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEF_HALF    = 50,
  parameter bit REVERSE_CLK = 1'b0
) (
  input  logic               i_clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_cfg_valid,
  input  logic [CNT_W-1:0]   i_cfg_half,
  output logic               o_cfg_ready,
  output logic               o_cfg_err,
  output logic               o_clk,
  output logic               o_tick,
  output logic               o_busy
`ifdef CLK_DIV_CTRL_BURST_EN
  ,
  input  logic [BURST_W-1:0] i_burst_len,
  output logic               o_done
`endif
);

  state_t           r_state;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_cfg_err;
  logic             r_tick;

  logic w_clk_out;
  logic w_rise;
  logic w_fall;
  logic w_run;
  logic w_accept;
  logic w_cfg_zero;
  logic w_stop;
  logic w_start;
  logic w_to_idle;

  assign w_run      = (r_state != IDLE);
  assign w_accept   = i_cfg_valid && !r_pend_vld;
  assign w_cfg_zero = (i_cfg_half == '0);
  assign w_start    = (r_state == IDLE) && i_start && !i_stop;

`ifdef CLK_DIV_CTRL_BURST_EN
  logic [BURST_W-1:0] r_burst_len;
  logic [BURST_W-1:0] r_burst_cnt;
  logic               r_done;
  logic               w_burst_hit;

  assign w_burst_hit = (r_burst_len != '0) && (r_burst_cnt == r_burst_len);
  assign w_stop      = i_stop || w_burst_hit;
  assign o_done      = r_done;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_burst_len <= '0;
      r_burst_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_to_idle;
      if (w_start) begin
        r_burst_len <= i_burst_len;
        r_burst_cnt <= '0;
      end else if (w_rise && !w_to_idle) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end
  end
`else
  assign w_stop = i_stop;
`endif

  // Low phase may be cut short safely; a high phase must always finish via a fall.
  assign w_to_idle = ((r_state == RUN) && w_stop && (!w_clk_out || w_fall)) ||
                     ((r_state == STOP) && w_fall);

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .i_clk         (i_clk),
    .rst           (rst),
    .i_run         (w_run),
    .i_clr         (w_to_idle),
    .i_half        (r_half),
    .o_clk_out     (w_clk_out),
    .o_toggle_rise (w_rise),
    .o_toggle_fall (w_fall)
  );

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_half     <= CNT_W'(DEF_HALF);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_cfg_err <= w_accept && w_cfg_zero;
      r_tick    <= w_rise && !w_to_idle;

      case (r_state)
        IDLE:    if (w_start) r_state <= RUN;
        RUN:     if (w_to_idle) r_state <= IDLE;
                 else if (w_stop) r_state <= STOP;
        STOP:    if (w_fall) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // A new ratio only lands where cnt restarts from 1 with clk_out low.
      if (r_pend_vld && (w_fall || w_to_idle || r_state == IDLE)) begin
        r_half     <= r_pend;
        r_pend_vld <= 1'b0;
      end else if (w_accept && !w_cfg_zero) begin
        if (r_state == IDLE) begin
          r_half <= i_cfg_half;
        end else begin
          r_pend     <= i_cfg_half;
          r_pend_vld <= 1'b1;
        end
      end
    end
  end

  assign o_cfg_ready = !r_pend_vld;
  assign o_cfg_err   = r_cfg_err;
  assign o_clk       = w_clk_out ^ REVERSE_CLK;
  assign o_tick      = r_tick;
  assign o_busy      = w_run;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (DEF_HALF=50, REVERSE_CLK=0).
module tb_clk_div_ctrl;

  logic        i_clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic [31:0] i_cfg_half = '0;
  logic        o_cfg_ready, o_cfg_err, o_clk, o_tick, o_busy;
`ifdef CLK_DIV_CTRL_BURST_EN
  logic [15:0] i_burst_len = '0;
  logic        o_done;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int e       = 0;

  always #5 i_clk = ~i_clk;

  clk_div_ctrl #(
    .CNT_W       (32),
    .DEF_HALF    (50),
    .REVERSE_CLK (1'b0)
  ) dut (
    .i_clk       (i_clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_half  (i_cfg_half),
    .o_cfg_ready (o_cfg_ready),
    .o_cfg_err   (o_cfg_err),
    .o_clk       (o_clk),
    .o_tick      (o_tick),
    .o_busy      (o_busy)
`ifdef CLK_DIV_CTRL_BURST_EN
    ,
    .i_burst_len (i_burst_len),
    .o_done      (o_done)
`endif
  );

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
    e++;
  endtask

  task automatic start_run();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    e = 0;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    n_total++; if (o_clk !== 1'b0) $display("FAIL reset_clk got=%b exp=0", o_clk); else n_pass++;
    n_total++; if (o_cfg_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", o_cfg_ready); else n_pass++;
    n_total++; if (o_cfg_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", o_cfg_err); else n_pass++;
    n_total++; if (o_tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", o_tick); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", o_busy); else n_pass++;
    rst = 1'b0;
    step();
    $display("reset: clk=%b ready=%b busy=%b", o_clk, o_cfg_ready, o_busy);
  endtask

  task automatic test_default_period();
    int bad = 0;
    int first_bad = -1;
    int ticks = 0;
    logic exp_clk, exp_tick;
    start_run();
    n_total++; if (o_busy !== 1'b1) $display("FAIL start_busy got=%b exp=1", o_busy); else n_pass++;
    for (int k = 1; k <= 259; k++) begin
      step();
      exp_clk  = ((e / 50) % 2) == 1;
      exp_tick = (e % 100) == 50;
      if (o_clk !== exp_clk || o_tick !== exp_tick) begin
        bad++;
        if (first_bad < 0) first_bad = e;
      end
      if (o_tick === 1'b1) ticks++;
    end
    n_total++; if (bad !== 0) $display("FAIL period50_pattern got=%0d bad cycles (first at edge %0d) exp=0", bad, first_bad); else n_pass++;
    n_total++; if (ticks !== 3) $display("FAIL period50_ticks got=%0d exp=3", ticks); else n_pass++;
    $display("default period: edges=%0d bad=%0d ticks=%0d", e, bad, ticks);
  endtask

  task automatic test_stop_high();
    n_total++; if (o_clk !== 1'b1) $display("FAIL stop_high_pre got=%b exp=1", o_clk); else n_pass++;
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    n_total++; if (o_busy !== 1'b1 || o_clk !== 1'b1) $display("FAIL stop_high_enter got busy=%b clk=%b exp busy=1 clk=1", o_busy, o_clk); else n_pass++;
    while (e < 299) step();
    n_total++; if (o_busy !== 1'b1 || o_clk !== 1'b1) $display("FAIL stop_high_hold got busy=%b clk=%b exp busy=1 clk=1", o_busy, o_clk); else n_pass++;
    step();
    n_total++; if (o_busy !== 1'b0 || o_clk !== 1'b0) $display("FAIL stop_high_done got busy=%b clk=%b exp busy=0 clk=0", o_busy, o_clk); else n_pass++;
    $display("stop in high phase: idle at edge %0d busy=%b", e, o_busy);
  endtask

  task automatic test_start_stop_together();
    i_start = 1'b1;
    i_stop  = 1'b1;
    step();
    i_start = 1'b0;
    i_stop  = 1'b0;
    n_total++; if (o_busy !== 1'b0) $display("FAIL start_stop_busy got=%b exp=0", o_busy); else n_pass++;
    step();
    n_total++; if (o_busy !== 1'b0 || o_clk !== 1'b0) $display("FAIL start_stop_idle got busy=%b clk=%b exp busy=0 clk=0", o_busy, o_clk); else n_pass++;
    $display("start+stop together: busy=%b", o_busy);
  endtask

  task automatic test_stop_low();
    int highs = 0;
    start_run();
    while (e < 10) step();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    n_total++; if (o_busy !== 1'b0 || o_clk !== 1'b0) $display("FAIL stop_low_idle got busy=%b clk=%b exp busy=0 clk=0", o_busy, o_clk); else n_pass++;
    for (int k = 0; k < 60; k++) begin
      step();
      if (o_clk === 1'b1 || o_tick === 1'b1) highs++;
    end
    n_total++; if (highs !== 0) $display("FAIL stop_low_quiet got=%0d high cycles exp=0", highs); else n_pass++;
    $display("stop in low phase: busy=%b highs=%0d", o_busy, highs);
  endtask

  task automatic test_cfg_pending();
    int bad = 0;
    i_cfg_valid = 1'b1;
    i_cfg_half  = 32'd3;
    n_total++; if (o_cfg_ready !== 1'b1) $display("FAIL cfg_idle_ready got=%b exp=1", o_cfg_ready); else n_pass++;
    step();
    i_cfg_valid = 1'b0;
    n_total++; if (o_cfg_err !== 1'b0) $display("FAIL cfg_idle_err got=%b exp=0", o_cfg_err); else n_pass++;
    start_run();
    for (int k = 1; k <= 16; k++) begin
      step();
      if (o_clk !== (((e / 3) % 2) == 1) || o_tick !== ((e % 6) == 3)) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL period3_pattern got=%0d bad cycles exp=0", bad); else n_pass++;
    i_cfg_valid = 1'b1;
    i_cfg_half  = 32'd1;
    step();
    i_cfg_valid = 1'b0;
    n_total++; if (o_cfg_ready !== 1'b0 || o_clk !== 1'b1) $display("FAIL pend_hold got ready=%b clk=%b exp ready=0 clk=1", o_cfg_ready, o_clk); else n_pass++;
    step();
    n_total++; if (o_cfg_ready !== 1'b1 || o_clk !== 1'b0) $display("FAIL pend_apply got ready=%b clk=%b exp ready=1 clk=0", o_cfg_ready, o_clk); else n_pass++;
    step();
    n_total++; if (o_clk !== 1'b1 || o_tick !== 1'b1) $display("FAIL half1_rise got clk=%b tick=%b exp clk=1 tick=1", o_clk, o_tick); else n_pass++;
    step();
    n_total++; if (o_clk !== 1'b0 || o_tick !== 1'b0) $display("FAIL half1_fall got clk=%b tick=%b exp clk=0 tick=0", o_clk, o_tick); else n_pass++;
    step();
    n_total++; if (o_clk !== 1'b1) $display("FAIL half1_rise2 got=%b exp=1", o_clk); else n_pass++;
    $display("cfg 3 then pending 1: edge=%0d clk=%b ready=%b", e, o_clk, o_cfg_ready);
  endtask

  task automatic test_cfg_zero();
    i_cfg_valid = 1'b1;
    i_cfg_half  = 32'd0;
    step();
    i_cfg_valid = 1'b0;
    n_total++; if (o_cfg_err !== 1'b1 || o_cfg_ready !== 1'b1) $display("FAIL zero_run_err got err=%b ready=%b exp err=1 ready=1", o_cfg_err, o_cfg_ready); else n_pass++;
    n_total++; if (o_clk !== 1'b0) $display("FAIL zero_run_clk got=%b exp=0", o_clk); else n_pass++;
    step();
    n_total++; if (o_cfg_err !== 1'b0 || o_clk !== 1'b1) $display("FAIL zero_run_after got err=%b clk=%b exp err=0 clk=1", o_cfg_err, o_clk); else n_pass++;
    step();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    n_total++; if (o_busy !== 1'b0 || o_clk !== 1'b0 || o_tick !== 1'b0) $display("FAIL zero_stop got busy=%b clk=%b tick=%b exp 0 0 0", o_busy, o_clk, o_tick); else n_pass++;
    i_cfg_valid = 1'b1;
    i_cfg_half  = 32'd0;
    step();
    i_cfg_valid = 1'b0;
    n_total++; if (o_cfg_err !== 1'b1) $display("FAIL zero_idle_err got=%b exp=1", o_cfg_err); else n_pass++;
    step();
    n_total++; if (o_cfg_err !== 1'b0) $display("FAIL zero_idle_pulse got=%b exp=0", o_cfg_err); else n_pass++;
    start_run();
    step();
    n_total++; if (o_clk !== 1'b1) $display("FAIL zero_keep_half_rise got=%b exp=1", o_clk); else n_pass++;
    step();
    n_total++; if (o_clk !== 1'b0) $display("FAIL zero_keep_half_fall got=%b exp=0", o_clk); else n_pass++;
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    $display("cfg 0 in run and idle: busy=%b err=%b", o_busy, o_cfg_err);
  endtask

  task automatic test_reset_mid();
    start_run();
    step();
    n_total++; if (o_clk !== 1'b1) $display("FAIL rst_mid_pre got=%b exp=1", o_clk); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (o_clk !== 1'b0 || o_busy !== 1'b0 || o_cfg_ready !== 1'b1) $display("FAIL rst_async got clk=%b busy=%b ready=%b exp 0 0 1", o_clk, o_busy, o_cfg_ready); else n_pass++;
    @(negedge i_clk);
    rst = 1'b0;
    step();
    start_run();
    while (e < 49) step();
    n_total++; if (o_clk !== 1'b0) $display("FAIL rst_def_half_49 got=%b exp=0", o_clk); else n_pass++;
    step();
    n_total++; if (o_clk !== 1'b1) $display("FAIL rst_def_half_50 got=%b exp=1", o_clk); else n_pass++;
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    for (int k = 0; k < 200 && o_busy === 1'b1; k++) step();
    n_total++; if (o_busy !== 1'b0) $display("FAIL rst_mid_stop_timeout got busy=%b exp=0", o_busy); else n_pass++;
    $display("reset mid-high: default half restored, busy=%b", o_busy);
  endtask

`ifdef CLK_DIV_CTRL_BURST_EN
  task automatic test_burst();
    int ticks = 0;
    int dones = 0;
    int done_at = -1;
    i_cfg_valid = 1'b1;
    i_cfg_half  = 32'd2;
    step();
    i_cfg_valid = 1'b0;
    i_burst_len = 16'd4;
    start_run();
    i_burst_len = 16'd0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (o_tick === 1'b1) ticks++;
      if (o_done === 1'b1) begin
        dones++;
        done_at = e;
      end
      if (e == 15) begin
        n_total++; if (o_busy !== 1'b1 || o_clk !== 1'b1) $display("FAIL burst_last_high got busy=%b clk=%b exp 1 1", o_busy, o_clk); else n_pass++;
      end
      if (e == 16) begin
        n_total++; if (o_busy !== 1'b0 || o_clk !== 1'b0) $display("FAIL burst_idle got busy=%b clk=%b exp 0 0", o_busy, o_clk); else n_pass++;
      end
    end
    n_total++; if (ticks !== 4) $display("FAIL burst_ticks got=%0d exp=4", ticks); else n_pass++;
    n_total++; if (dones !== 1 || done_at !== 16) $display("FAIL burst_done got count=%0d at=%0d exp count=1 at=16", dones, done_at); else n_pass++;
    $display("burst len 4 half 2: ticks=%0d done_at=%0d", ticks, done_at);
  endtask
`endif

  initial begin
    test_reset();
    test_default_period();
    test_stop_high();
    test_start_stop_together();
    test_stop_low();
    test_cfg_pending();
    test_cfg_zero();
    test_reset_mid();
`ifdef CLK_DIV_CTRL_BURST_EN
    test_burst();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time controller for a 50%-duty clock divider: start/stop sequencing and divide-ratio programming over a valid/ready handshake.
- Ratio changes and stops take effect only at period boundaries, so the output never shows a runt high pulse.
- Sits between the system control/register logic and the divided-clock consumers (sample strobes, slow FSMs); also emits a one-cycle tick enable.

Parameters:
- CNT_W, 32, width of the half-period count and the config value.
- DEF_HALF, 50, half-period in i_clk cycles loaded at reset (100 Hz to 1 Hz equivalent).
- REVERSE_CLK, 0, when 1, o_clk is the inverted internal clock level.

Ports:
- i_clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- i_start  in  1  level/pulse; sampled each cycle; begin dividing.
- i_stop  in  1  level/pulse; sampled each cycle; stop dividing.
- i_cfg_valid  in  1  config request valid.
- i_cfg_half  in  CNT_W  requested half-period in cycles.
- o_cfg_ready  out  1  config can be accepted this cycle.
- o_cfg_err  out  1  one-cycle pulse: accepted config was 0 and is discarded.
- o_clk  out  1  divided clock, = clk_out XOR REVERSE_CLK.
- o_tick  out  1  one-cycle pulse in the first cycle clk_out is high.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE, cnt=1, clk_out=0 (so o_clk=REVERSE_CLK), half=DEF_HALF, pend_vld=0, o_cfg_ready=1, o_cfg_err=0, o_tick=0, o_busy=0. All outputs are registered or derived from registers.
- States:
  - IDLE: clk_out=0 and cnt=1 are held. A config with valid&ready and value≠0 loads half on the same edge. A value of 0 pulses o_cfg_err the next cycle and half is unchanged. With i_start=1 and i_stop=0, go to RUN. With start and stop together, stay in IDLE.
  - RUN: each edge, if cnt==half then clk_out toggles and cnt=1; else cnt=cnt+1. The first rising edge of o_clk occurs half edges after the start edge. half=1 gives divide-by-2. Width rule: cnt wraps never, because half≥1 always.
  - STOP: counting continues. At the toggle 1→0, go to IDLE with cnt=1.
- Config in RUN/STOP: an accepted value goes to the pending register, pend_vld=1, and o_cfg_ready=0 while pend_vld. The pending value is copied to half on the clk_out 1→0 toggle edge, or on entering IDLE, whichever comes first. o_cfg_ready returns to 1 the next cycle. A value of 0 is rejected with o_cfg_err and never becomes pending.
- i_stop in RUN:
  - clk_out=0: go to IDLE next edge (low phase truncated, which is safe).
  - clk_out=1: go to STOP.
  - i_start is ignored outside IDLE.
- o_tick=1 for exactly the cycle following the 0→1 toggle edge, once per output period.
- Reset asserted mid-operation clears everything asynchronously. Any pending config is lost.

Optional Feature:
- Macro: CLK_DIV_CTRL_BURST_EN.
- Defined:
  - Adds ports i_burst_len (in, 16) and o_done (out, 1).
  - i_burst_len is latched on the start edge. If nonzero, the block counts rising toggles and, on the count reaching i_burst_len, behaves as if i_stop were sampled in that cycle.
  - o_done pulses for one cycle on each return to IDLE, whether caused by burst completion or by i_stop.
  - A latched length of 0 means free-running.
- Undefined: the ports are absent, and the block runs until i_stop.

Decomposition:
- Shared package clk_div_pkg holds:
  - the state typedef (IDLE, RUN, STOP; 2-bit encoding);
  - the default CNT_W;
  - the BURST_W=16 constant.
- One natural sub-module, clk_div_core: the cnt/clk_out toggle engine with inputs run, clr, and half, and outputs clk_out and toggle_rise/toggle_fall strobes. clk_div_ctrl owns the FSM, the pending register and the handshake.

Test Plan:
- Reset with DEF_HALF=50, start at edge 0 → first o_clk rise at edge 50, period 100 cycles, o_tick once per period, duty exactly 50/50.
- In IDLE send cfg 3, then start → o_clk toggles every 3 cycles. In RUN send cfg 1 with clk_out high → ready low until the next fall; the new period is 2 cycles from that fall and o_cfg_ready high one cycle later.
- Send cfg 0 in IDLE and in RUN → o_cfg_err pulses once each, the period is unchanged, and no pending value is set.
- Stop with clk_out high at cnt 10 of 50 → high phase completes (40 more cycles), then IDLE with o_busy=0. Stop with clk_out low → IDLE next edge, o_clk stays low.
- Start and stop asserted together in IDLE → remains IDLE. Assert rst mid-high-phase → o_clk=REVERSE_CLK immediately, half=DEF_HALF.
- BURST_EN with i_burst_len=4, half=2 → exactly 4 o_tick pulses, last fall, then o_done pulse and IDLE.
